// File: rtl/mc_main_fsm.sv
// rtl/mc_main_fsm.sv - multicycle MIPS main control FSM with memory handshake and opcode trap
module mc_main_fsm #(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter bit TRAP_EN       = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       iord,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic       branch_eq,
   output logic       branch_ne,
   output logic       imm_zext,
   output logic       illegal_op,
   output logic [1:0] reg_dst,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTYPE  = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_IMMWB  = 4'd10,
      S_JUMP   = 4'd11,
      S_ORIEX  = 4'd12,
      S_JAL    = 4'd13,
      S_TRAP   = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   state_t     state_q, state_d;
   logic [5:0] op_q, op_d;
   logic       ready;
   logic       op_legal;

   // With the handshake disabled every memory state completes in one cycle.
   assign ready    = mem_ready | !MEM_HANDSHAKE;
   assign op_legal = opcode inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
                                    OP_ADDI, OP_ORI, OP_LW, OP_SW};

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      case (state_q)
         S_FETCH:  if (ready) state_d = S_DECODE;
         S_DECODE: begin
            op_d = opcode;
            case (opcode)
               OP_RTYPE:     state_d = S_RTYPE;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_ORI:       state_d = S_ORIEX;
               OP_J:         state_d = S_JUMP;
               OP_JAL:       state_d = S_JAL;
               default: begin
                  if (TRAP_EN) state_d = S_TRAP;
                  else         state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            if (op_q == OP_LW) state_d = S_MEMRD;
            else               state_d = S_MEMWR;
         end
         S_MEMRD:  if (ready) state_d = S_MEMWB;
         S_MEMWR:  if (ready) state_d = S_FETCH;
         S_RTYPE:  state_d = S_ALUWB;
         S_ADDIEX: state_d = S_IMMWB;
         S_ORIEX:  state_d = S_IMMWB;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         op_q    <= 6'h00;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // Moore decode; only the FETCH write enables and the non-trapping illegal flag look at inputs.
   always_comb begin
      pc_write   = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      branch_eq  = 1'b0;
      branch_ne  = 1'b0;
      imm_zext   = 1'b0;
      illegal_op = 1'b0;
      reg_dst    = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      state_o    = state_q;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            pc_write  = ready;
            ir_write  = ready;
         end
         S_DECODE: begin
            alu_src_b  = 2'b11;
            illegal_op = !TRAP_EN && !op_legal;
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_RTYPE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 2'b01;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            branch_eq = (op_q == OP_BEQ);
            branch_ne = (op_q == OP_BNE);
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_ORIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
            imm_zext  = 1'b1;
         end
         S_IMMWB: reg_write = 1'b1;
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
         end
         S_JAL: begin
            pc_write  = 1'b1;
            pc_src    = 2'b10;
            reg_write = 1'b1;
            reg_dst   = 2'b10;
         end
         S_TRAP: begin
            pc_write   = 1'b1;
            pc_src     = 2'b11;
            illegal_op = 1'b1;
         end
         default: state_o = 4'd15;
      endcase
   end

endmodule

// File: tb/tb_mc_main_fsm.sv
// tb/tb_mc_main_fsm.sv - scoreboard bench for mc_main_fsm, trapping and non-trapping builds
module tb_mc_main_fsm;

   typedef struct packed {
      logic       pc_write, iord, ir_write, mem_read, mem_write, reg_write, mem_to_reg, alu_src_a;
      logic       branch_eq, branch_ne, imm_zext, illegal_op;
      logic [1:0] reg_dst, alu_src_b, alu_op, pc_src;
      logic [3:0] st;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op_1 = 6'h00, op_0 = 6'h00;
   logic       rdy_1 = 1'b0, rdy_0 = 1'b0;
   int         checks = 0;
   int         errors = 0;
   exp_t       q1[$];
   exp_t       q0[$];

   logic       pcw_1, iord_1, irw_1, mrd_1, mwr_1, rw_1, m2r_1, asa_1, beq_1, bne_1, zx_1, ill_1;
   logic [1:0] rd_1, asb_1, aop_1, pcs_1;
   logic [3:0] st_1;
   logic       pcw_0, iord_0, irw_0, mrd_0, mwr_0, rw_0, m2r_0, asa_0, beq_0, bne_0, zx_0, ill_0;
   logic [1:0] rd_0, asb_0, aop_0, pcs_0;
   logic [3:0] st_0;
   exp_t       g1, g0;

   assign g1 = {pcw_1, iord_1, irw_1, mrd_1, mwr_1, rw_1, m2r_1, asa_1, beq_1, bne_1, zx_1, ill_1,
                rd_1, asb_1, aop_1, pcs_1, st_1};
   assign g0 = {pcw_0, iord_0, irw_0, mrd_0, mwr_0, rw_0, m2r_0, asa_0, beq_0, bne_0, zx_0, ill_0,
                rd_0, asb_0, aop_0, pcs_0, st_0};

   always #5 clk = ~clk;

   mc_main_fsm #(.MEM_HANDSHAKE(1'b1), .TRAP_EN(1'b1)) dut_trap (
      .clk(clk), .rst_n(rst_n), .opcode(op_1), .mem_ready(rdy_1),
      .pc_write(pcw_1), .iord(iord_1), .ir_write(irw_1), .mem_read(mrd_1), .mem_write(mwr_1),
      .reg_write(rw_1), .mem_to_reg(m2r_1), .alu_src_a(asa_1), .branch_eq(beq_1),
      .branch_ne(bne_1), .imm_zext(zx_1), .illegal_op(ill_1), .reg_dst(rd_1),
      .alu_src_b(asb_1), .alu_op(aop_1), .pc_src(pcs_1), .state_o(st_1));

   mc_main_fsm #(.MEM_HANDSHAKE(1'b1), .TRAP_EN(1'b0)) dut_notrap (
      .clk(clk), .rst_n(rst_n), .opcode(op_0), .mem_ready(rdy_0),
      .pc_write(pcw_0), .iord(iord_0), .ir_write(irw_0), .mem_read(mrd_0), .mem_write(mwr_0),
      .reg_write(rw_0), .mem_to_reg(m2r_0), .alu_src_a(asa_0), .branch_eq(beq_0),
      .branch_ne(bne_0), .imm_zext(zx_0), .illegal_op(ill_0), .reg_dst(rd_0),
      .alu_src_b(asb_0), .alu_op(aop_0), .pc_src(pcs_0), .state_o(st_0));

   task automatic chk(input string name, input exp_t got, input exp_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (state got %0d exp %0d)", name, got, exp, got.st, exp.st);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};
   endfunction

   function automatic exp_t fetch_exp(input bit rdy);
      exp_t e = '0;
      e.mem_read  = 1'b1;
      e.alu_src_b = 2'b01;
      e.pc_write  = rdy;
      e.ir_write  = rdy;
      return e;
   endfunction

   // Monitor: every cycle a driver has scheduled is compared against its queued expectation.
   always @(negedge clk) begin
      if (q1.size() > 0) chk($sformatf("trap_en1_st%0d", q1[0].st), g1, q1.pop_front());
      if (q0.size() > 0) chk($sformatf("trap_en0_st%0d", q0[0].st), g0, q0.pop_front());
   end

   // Reference: the cycle-by-cycle control sequence one instruction produces, from FETCH onward.
   task automatic run_instr(input bit sel, input logic [5:0] op, input int fw, input int mw,
                            input int ncyc);
      exp_t       seq[$];
      bit         rs[$];
      logic [5:0] os[$];
      exp_t       e;
      int         n;
      for (int i = 0; i < fw; i++) begin
         seq.push_back(fetch_exp(1'b0)); rs.push_back(1'b0); os.push_back(6'($urandom));
      end
      seq.push_back(fetch_exp(1'b1)); rs.push_back(1'b1); os.push_back(6'($urandom));
      e = '0; e.st = 4'd1; e.alu_src_b = 2'b11; e.illegal_op = !is_legal(op) && !sel;
      seq.push_back(e); rs.push_back(1'($urandom)); os.push_back(op);
      e = '0;
      case (op)
         6'h00: begin
            e.st = 4'd6; e.alu_src_a = 1; e.alu_op = 2'b10; seq.push_back(e);
            e = '0; e.st = 4'd7; e.reg_write = 1; e.reg_dst = 2'b01; seq.push_back(e);
         end
         6'h23, 6'h2B: begin
            e.st = 4'd2; e.alu_src_a = 1; e.alu_src_b = 2'b10; seq.push_back(e);
            rs.push_back(1'($urandom)); os.push_back(6'($urandom));
            e = '0; e.iord = 1;
            if (op == 6'h23) begin e.st = 4'd3; e.mem_read = 1; end
            else begin e.st = 4'd5; e.mem_write = 1; end
            for (int i = 0; i <= mw; i++) begin
               seq.push_back(e); rs.push_back(i == mw); os.push_back(6'($urandom));
            end
            if (op == 6'h23) begin
               e = '0; e.st = 4'd4; e.reg_write = 1; e.mem_to_reg = 1; seq.push_back(e);
            end
         end
         6'h04, 6'h05: begin
            e.st = 4'd8; e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01;
            e.branch_eq = (op == 6'h04); e.branch_ne = (op == 6'h05); seq.push_back(e);
         end
         6'h08, 6'h0D: begin
            e.st = (op == 6'h08) ? 4'd9 : 4'd12; e.alu_src_a = 1; e.alu_src_b = 2'b10;
            if (op == 6'h0D) begin e.alu_op = 2'b11; e.imm_zext = 1; end
            seq.push_back(e);
            e = '0; e.st = 4'd10; e.reg_write = 1; seq.push_back(e);
         end
         6'h02: begin
            e.st = 4'd11; e.pc_write = 1; e.pc_src = 2'b10; seq.push_back(e);
         end
         6'h03: begin
            e.st = 4'd13; e.pc_write = 1; e.pc_src = 2'b10; e.reg_write = 1; e.reg_dst = 2'b10;
            seq.push_back(e);
         end
         default: if (sel) begin
            e.st = 4'd14; e.pc_write = 1; e.pc_src = 2'b11; e.illegal_op = 1; seq.push_back(e);
         end
      endcase
      while (rs.size() < seq.size()) begin
         rs.push_back(1'($urandom)); os.push_back(6'($urandom));
      end
      n = (ncyc < 0) ? seq.size() : ncyc;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (sel) begin op_1 = os[i]; rdy_1 = rs[i]; rdy_0 = 1'b0; q1.push_back(seq[i]); end
         else     begin op_0 = os[i]; rdy_0 = rs[i]; rdy_1 = 1'b0; q0.push_back(seq[i]); end
      end
   endtask

   function automatic logic [5:0] pick_op();
      logic [5:0] ops [9] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};
      int k = $urandom_range(0, 9);
      logic [5:0] op;
      if (k < 9) return ops[k];
      do op = 6'($urandom); while (is_legal(op));
      return op;
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_trap_en1", g1, fetch_exp(1'b0));
      chk("reset_trap_en0", g0, fetch_exp(1'b0));
      rst_n = 1'b1;

      run_instr(1'b1, 6'h00, 0, 0, -1);
      run_instr(1'b1, 6'h23, 0, 2, -1);
      run_instr(1'b1, 6'h2B, 3, 0, -1);
      run_instr(1'b1, 6'h05, 0, 0, -1);
      run_instr(1'b1, 6'h04, 1, 0, -1);
      run_instr(1'b1, 6'h0D, 0, 0, -1);
      run_instr(1'b1, 6'h03, 0, 0, -1);
      run_instr(1'b1, 6'h3F, 0, 0, -1);
      run_instr(1'b1, 6'h08, 0, 0, -1);
      run_instr(1'b1, 6'h02, 0, 0, -1);

      // Stop inside a stalled MEMWR and reset asynchronously.
      run_instr(1'b1, 6'h2B, 0, 2, 4);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1 chk("reset_in_memwr", g1, fetch_exp(1'b0));
      @(posedge clk); #1 rst_n = 1'b1;

      for (int i = 0; i < 40; i++)
         run_instr(1'b1, pick_op(), $urandom_range(0, 2), $urandom_range(0, 2), -1);

      run_instr(1'b0, 6'h3F, 0, 0, -1);
      run_instr(1'b0, 6'h00, 0, 0, -1);
      for (int i = 0; i < 30; i++)
         run_instr(1'b0, pick_op(), $urandom_range(0, 2), $urandom_range(0, 2), -1);

      for (int i = 0; i < 10 && (q1.size() > 0 || q0.size() > 0); i++) @(negedge clk);
      #2;
      checks++;
      if (q1.size() > 0 || q0.size() > 0) begin
         errors++;
         $display("FAIL drain got %0d pending exp 0", q1.size() + q0.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
